// File: rtl/column_input_ctrl.sv
// column_input_ctrl
//   Turns four raw column push-buttons into a single qualified column
//   selection for the game FSM. Each button is synchronized, debounced and
//   edge-detected; a small FSM (IDLE/STROBE/HOLD) accepts one clean press at
//   a time and refuses ambiguous (multi-button) presses.
//
//   Optional feature macro: COLFULL_FILTER_EN
//     defined   : presses on a full column (col_full[i]==1) are refused.
//     undefined : col_full is ignored and full-column presses are strobed.
//
// Ports
//   clk         : single clock, rising edge
//   reset       : synchronous, active-high
//   btn[3:0]    : raw asynchronous buttons, active-high, bit i = column i
//   game_status : 2'b00 = game in progress, anything else = game over
//   col_full    : bit i high = column i has no free cell
//   in_column   : active-low one-hot selected column, 4'b1111 = none
//   enable      : one-cycle strobe qualifying in_column
//   reject      : one-cycle strobe flagging a refused press
module column_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  input  logic [1:0] game_status,
  input  logic [3:0] col_full,
  output logic [3:0] in_column,
  output logic       enable,
  output logic       reject
);

  typedef enum logic [1:0] {IDLE, STROBE, HOLD} state_t;

  logic [3:0] sync1_reg;
  logic [3:0] sync2_reg;
  logic       deb_bit_reg [4];
  logic [7:0] cnt_reg [4];
  logic [3:0] deb;
  logic [3:0] deb_prev_reg;
  logic [3:0] press;
  logic       multi;
  logic       refused;
  logic [1:0] settle_reg;
  logic       armed_reg;

  state_t     state_reg, state_next;
  logic [3:0] in_column_reg, in_column_next;
  logic       reject_reg, reject_next;

  // Two-flop synchronizer for every button bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= 4'b0000;
      sync2_reg <= 4'b0000;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
    end
  end

  // Per-bit debouncer: the debounced bit flips only after the synchronized
  // bit has disagreed with it on DEBOUNCE_CYCLES consecutive edges.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_deb
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg[gi]     <= 8'd0;
          deb_bit_reg[gi] <= 1'b0;
        end else if (sync2_reg[gi] == deb_bit_reg[gi]) begin
          cnt_reg[gi] <= 8'd0;
        end else if (cnt_reg[gi] == 8'(DEBOUNCE_CYCLES - 1)) begin
          cnt_reg[gi]     <= 8'd0;
          deb_bit_reg[gi] <= ~deb_bit_reg[gi];
        end else begin
          cnt_reg[gi] <= cnt_reg[gi] + 8'd1;
        end
      end
      assign deb[gi] = deb_bit_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) deb_prev_reg <= 4'b0000;
    else       deb_prev_reg <= deb;
  end

  assign press = deb & ~deb_prev_reg;
  // More than one bit set: clearing the lowest set bit leaves something.
  assign multi = (deb & (deb - 4'd1)) != 4'd0;

`ifdef COLFULL_FILTER_EN
  assign refused = (deb & col_full) != 4'd0;
`else
  logic col_full_unused;
  assign col_full_unused = ^col_full;
  assign refused = 1'b0;
`endif

  // After reset the synchronizers read 0 regardless of the pins, so a button
  // held through reset would look like a fresh press. The FSM is only armed
  // once the pipeline has refilled and the buttons are seen released.
  always_ff @(posedge clk) begin
    if (reset) begin
      settle_reg <= 2'd0;
      armed_reg  <= 1'b0;
    end else begin
      if (settle_reg != 2'd2) settle_reg <= settle_reg + 2'd1;
      if (settle_reg == 2'd2 && sync2_reg == 4'd0 && deb == 4'd0) armed_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= HOLD;
      in_column_reg <= 4'b1111;
      reject_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      in_column_reg <= in_column_next;
      reject_reg    <= reject_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    in_column_next = in_column_reg;
    reject_next    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (press != 4'd0) begin
          state_next = HOLD;
          // Game over: swallow the press silently.
          if (game_status == 2'b00) begin
            if (multi || refused) begin
              reject_next = 1'b1;
            end else begin
              in_column_next = ~deb;
              state_next     = STROBE;
            end
          end
        end
      end
      STROBE: state_next = HOLD;
      HOLD: begin
        if (deb == 4'd0 && armed_reg) state_next = IDLE;
      end
      default: state_next = HOLD;
    endcase
  end

  assign enable    = (state_reg == STROBE);
  assign reject    = reject_reg;
  assign in_column = in_column_reg;

endmodule

// File: tb/tb_column_input_ctrl.sv
// Testbench for column_input_ctrl (DEBOUNCE_CYCLES=4): directed scenarios
// with literal expectations followed by randomized stimulus, all checked
// every cycle against a behavioural model.
module tb_column_input_ctrl;

  localparam int D = 4;
  localparam int M_IDLE = 0, M_STROBE = 1, M_HOLD = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn;
  logic [1:0] game_status;
  logic [3:0] col_full;
  logic [3:0] in_column;
  logic       enable;
  logic       reject;

  int total = 0;
  int bad = 0;
  int en_cnt = 0;
  int rej_cnt = 0;

  column_input_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .btn(btn), .game_status(game_status),
    .col_full(col_full), .in_column(in_column), .enable(enable), .reject(reject)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [3:0] hist[$];
  bit [3:0] m_deb = 0, m_deb_old = 0, m_col = 4'b1111;
  int       m_run [4];
  int       m_mode = M_HOLD;
  bit       m_armed = 0, m_en = 0, m_rej = 0;

  always @(posedge clk) begin
    bit [3:0] synced, press;
    bit       en_n, rej_n, refused;
    if (reset) begin
      hist.delete();
      m_deb = 0; m_deb_old = 0; m_col = 4'b1111;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_mode = M_HOLD; m_armed = 0; m_en = 0; m_rej = 0;
    end else begin
      // value that reached the debouncer this edge: btn from two edges ago
      synced = (hist.size() >= 2) ? hist[hist.size()-2] : 4'b0;
      press  = m_deb & ~m_deb_old;
`ifdef COLFULL_FILTER_EN
      refused = (col_full & m_deb) != 0;
`else
      refused = 0;
`endif
      en_n = 0; rej_n = 0;
      if (m_mode == M_STROBE) m_mode = M_HOLD;
      else if (m_mode == M_IDLE && press != 0) begin
        m_mode = M_HOLD;
        if (game_status == 2'b00) begin
          if ($countones(m_deb) > 1 || refused) rej_n = 1;
          else begin m_col = ~m_deb; en_n = 1; m_mode = M_STROBE; end
        end
      end else if (m_mode == M_HOLD && m_deb == 0 && m_armed) m_mode = M_IDLE;
      if (hist.size() >= 2 && synced == 0 && m_deb == 0) m_armed = 1;
      m_deb_old = m_deb;
      for (int i = 0; i < 4; i++) begin
        if (synced[i] != m_deb[i]) begin
          m_run[i]++;
          if (m_run[i] == D) begin m_deb[i] = ~m_deb[i]; m_run[i] = 0; end
        end else m_run[i] = 0;
      end
      m_en = en_n; m_rej = rej_n;
      hist.push_back(btn);
      if (hist.size() > 3) void'(hist.pop_front());
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("enable", {3'b0, enable}, {3'b0, m_en});
    chk("reject", {3'b0, reject}, {3'b0, m_rej});
    chk("in_column", in_column, m_col);
    chk("en_rej_exclusive", {3'b0, enable & reject}, 4'b0);
    if (enable) en_cnt++;
    if (reject) rej_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int cyc);
    reset = 1'b1;
    step(cyc);
    reset = 1'b0;
    step(6);
  endtask

  int e0, r0, k, len, bb, r;
  bit bounce;

  initial begin
    reset = 1'b1; btn = 4'b0; game_status = 2'b00; col_full = 4'b0;
    step(1);
    chk("reset_in_column", in_column, 4'b1111);
    chk("reset_enable", {3'b0, enable}, 4'b0);
    chk("reset_reject", {3'b0, reject}, 4'b0);
    reset = 1'b0;
    step(6);

    // clean press: latency of D+3 edges
    btn = 4'b0001; e0 = en_cnt; k = 0;
    while (k < 20) begin
      step(1); k++;
      if (enable) break;
    end
    chk("latency_edges", 4'(k), 4'd7);
    chk("clean_col", in_column, 4'b1110);
    chk("model_col_pin", m_col, 4'b1110);
    step(1);
    chk("strobe_one_cycle", {3'b0, enable}, 4'b0);
    step(10);
    chk("clean_count", 4'(en_cnt - e0), 4'd1);
    btn = 4'b0; step(10);

    // bounce on bit 2
    e0 = en_cnt;
    for (int i = 0; i < 10; i++) begin
      btn = (i % 2 == 1) ? 4'b0100 : 4'b0000;
      step(1);
    end
    chk("bounce_no_strobe", 4'(en_cnt - e0), 4'd0);
    btn = 4'b0100; step(12);
    chk("bounce_then_one", 4'(en_cnt - e0), 4'd1);
    chk("bounce_col", in_column, 4'b1011);
    btn = 4'b0; step(10);

    // second button while first held
    e0 = en_cnt;
    btn = 4'b0010; step(10);
    btn = 4'b0110; step(10);
    chk("overlap_one", 4'(en_cnt - e0), 4'd1);
    chk("overlap_col", in_column, 4'b1101);
    btn = 4'b0; step(10);
    chk("overlap_after_release", 4'(en_cnt - e0), 4'd1);
    btn = 4'b0100; step(10);
    chk("repress_two", 4'(en_cnt - e0), 4'd2);
    chk("repress_col", in_column, 4'b1011);
    btn = 4'b0; step(10);

    // simultaneous press -> reject
    e0 = en_cnt; r0 = rej_cnt;
    btn = 4'b1001; step(10);
    chk("multi_reject", 4'(rej_cnt - r0), 4'd1);
    chk("multi_no_enable", 4'(en_cnt - e0), 4'd0);
    chk("multi_col_kept", in_column, 4'b1011);
    btn = 4'b0; step(10);

    // game over
    e0 = en_cnt; r0 = rej_cnt;
    game_status = 2'b01; btn = 4'b0100; step(10);
    chk("gameover_no_enable", 4'(en_cnt - e0), 4'd0);
    chk("gameover_no_reject", 4'(rej_cnt - r0), 4'd0);
    btn = 4'b0; step(10); game_status = 2'b00;

    // full column
    e0 = en_cnt; r0 = rej_cnt;
    col_full = 4'b1000; btn = 4'b1000; step(10);
`ifdef COLFULL_FILTER_EN
    chk("full_reject", 4'(rej_cnt - r0), 4'd1);
    chk("full_no_enable", 4'(en_cnt - e0), 4'd0);
    chk("full_col_kept", in_column, 4'b1011);
`else
    chk("full_no_reject", 4'(rej_cnt - r0), 4'd0);
    chk("full_enable", 4'(en_cnt - e0), 4'd1);
    chk("full_col", in_column, 4'b0111);
`endif
    btn = 4'b0; col_full = 4'b0; step(10);

    // held through reset
    btn = 4'b0001; step(10);
    e0 = en_cnt;
    reset = 1'b1; step(2);
    chk("hold_reset_col", in_column, 4'b1111);
    reset = 1'b0; step(15);
    chk("hold_no_strobe", 4'(en_cnt - e0), 4'd0);
    chk("hold_col_none", in_column, 4'b1111);
    btn = 4'b0; step(10);
    btn = 4'b0001; step(10);
    chk("hold_repress", 4'(en_cnt - e0), 4'd1);
    chk("hold_repress_col", in_column, 4'b1110);
    btn = 4'b0; step(10);

    // randomized phase, checked by the per-cycle compare
    for (int s = 0; s < 400; s++) begin
      r = $urandom_range(0, 9);
      bounce = 0;
      if (r <= 2)      btn = 4'b0;
      else if (r <= 6) btn = 4'(1 << $urandom_range(0, 3));
      else if (r == 7) btn = 4'($urandom);
      else if (r == 8) begin bounce = 1; bb = $urandom_range(0, 3); end
      game_status = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      col_full = 4'($urandom);
      if ($urandom_range(0, 30) == 0) begin
        reset = 1'b1; step($urandom_range(1, 3)); reset = 1'b0;
      end
      len = $urandom_range(1, 14);
      for (int j = 0; j < len; j++) begin
        if (bounce) btn[bb] = ~btn[bb];
        step(1);
      end
    end
    btn = 4'b0; step(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/column_input_ctrl.md
COLUMN_INPUT_CTRL -- requirements
Module: column_input_ctrl

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable synchronized samples needed to change a debounced button state (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port btn, input, 4 bits: raw asynchronous column push-buttons, active-high; bit i selects column i.
REQ-005 The block SHALL have port game_status, input, 2 bits: game FSM status; 2'b00 means game in progress, any other value means game over.
REQ-006 The block SHALL have port col_full, input, 4 bits: bit i high means column i has no free cell.
REQ-007 The block SHALL have port in_column, output, 4 bits: active-low one-hot selected column (4'b1110 = column 0); 4'b1111 = none.
REQ-008 The block SHALL have port enable, output, 1 bit: single-cycle strobe qualifying in_column to the game FSM.
REQ-009 The block SHALL have port reject, output, 1 bit: single-cycle strobe flagging a refused press.

Function
REQ-010 Each btn bit SHALL pass through a two-flop synchronizer before any other use.
REQ-011 Each bit SHALL own a debounce counter; the debounced bit SHALL toggle only after the synchronized bit differs from it on DEBOUNCE_CYCLES consecutive edges; any agreeing sample SHALL clear the counter.
REQ-012 A press event SHALL be a 0-to-1 transition of a debounced bit.
REQ-013 The FSM SHALL have states IDLE, STROBE and HOLD, and SHALL reset to HOLD.
REQ-014 In IDLE, when exactly one debounced bit is high, that bit has a press event, game_status==00 and the column is not refused (REQ-021), the FSM SHALL load in_column with the active-low one-hot of that column and go to STROBE.
REQ-015 In STROBE, enable SHALL be 1 for exactly that one cycle, and the FSM SHALL then go to HOLD.
REQ-016 In HOLD, the FSM SHALL return to IDLE only in the cycle after all four debounced bits are low; presses while in HOLD SHALL be ignored.
REQ-017 In IDLE, if a press event occurs while more than one debounced bit is high, the block SHALL pulse reject for one cycle, leave in_column unchanged and go to HOLD.
REQ-018 If game_status!=00, a press event SHALL produce no enable and no reject, leave in_column unchanged, and move the FSM to HOLD.
REQ-019 in_column SHALL hold its last accepted value until the next accepted press or reset.
REQ-020 Latency: for a clean press, enable SHALL be high in the cycle following the (DEBOUNCE_CYCLES+3)th consecutive rising edge at which btn is sampled high; in_column SHALL be valid in the same cycle and after it.
REQ-021 A column SHALL be refused when col_full[i]==1 in the press cycle and COLFULL_FILTER_EN is defined.
REQ-022 A refused column SHALL pulse reject, produce no enable and go to HOLD.
REQ-023 enable and reject SHALL never be high in the same cycle.

Reset
REQ-024 While reset is high, the block SHALL set in_column=4'b1111, enable=0 and reject=0.
REQ-025 While reset is high, the block SHALL clear the synchronizers, debounced bits and counters to 0, and set the FSM to HOLD.
REQ-026 Reset during STROBE SHALL deassert enable on the next edge, with no further strobe.
REQ-027 A button held through reset SHALL produce no strobe until it is released and pressed again.

Configuration
REQ-028 With macro COLFULL_FILTER_EN defined, presses on full columns SHALL be refused per REQ-021 and REQ-022.
REQ-029 Without COLFULL_FILTER_EN, the col_full port SHALL remain present but be ignored, and full-column presses SHALL be strobed normally (the game FSM discards them).

Verification (DEBOUNCE_CYCLES=4)
REQ-030 Stimulus: after reset, btn=0001 held clean. Response: enable high exactly one cycle, 7 edges after the first sampled-high edge; in_column=1110.
REQ-031 Stimulus: btn bit 2 bounces 0/1 every cycle for 10 cycles, then is held high. Response: no enable during the bounce; then one strobe with in_column=1011.
REQ-032 Stimulus: btn=0010 held, then 0110 before bit 1 is released. Response: one strobe only (in_column=1101); no strobe for bit 2 until all buttons are released and bit 2 is pressed again.
REQ-033 Stimulus: btn=1001 pressed in the same cycle. Response: reject one cycle; no enable; in_column unchanged.
REQ-034 Stimulus: game_status=01 with btn=0100 pressed. Response: no enable and no reject. With COLFULL_FILTER_EN, col_full=1000 and btn=1000 pressed: reject pulses and there is no enable.
REQ-035 Stimulus: btn=0001 held through a 2-cycle reset pulse. Response: in_column=1111 and no enable until release and re-press.
